mtimer: RTL and testbench
=========================

MTIMER -- requirements
Module: mtimer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1; meaning: number of i_clk cycles per mtime increment, legal range 1..65535.
REQ-002 SHALL have port i_clk, input, 1 bit; the single clock, all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port i_req_valid, input, 1 bit; a bus request is present.
REQ-005 SHALL have port o_req_ready, output, 1 bit; the request is accepted when i_req_valid and o_req_ready are both 1.
REQ-006 SHALL have port i_req_we, input, 1 bit; 1 = write, 0 = read.
REQ-007 SHALL have port i_req_addr, input, 5 bits; byte offset into the register map.
REQ-008 SHALL have port i_req_wdata, input, MXLEN (32) bits; write data.
REQ-009 SHALL have port o_rsp_valid, output, 1 bit; a response is held.
REQ-010 SHALL have port i_rsp_ready, input, 1 bit; the response is consumed when o_rsp_valid and i_rsp_ready are both 1.
REQ-011 SHALL have port o_rsp_rdata, output, 32 bits; read data, 0 for writes and errors.
REQ-012 SHALL have port o_rsp_err, output, 1 bit; the access was illegal.
REQ-013 SHALL have port o_mtip, output, 1 bit; machine timer interrupt pending, wired to the CSR file mtip input.
REQ-014 SHALL have port o_msip, output, 1 bit; machine software interrupt pending (msip bit 0).

Function
REQ-015 SHALL use this register map: 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32], 0x10 msip (bit 0 writable, bits 31:1 read 0).
REQ-016 SHALL drive o_req_ready = !o_rsp_valid || i_rsp_ready, which gives a single response slot.
REQ-017 SHALL register the response in the cycle after acceptance, giving 1-cycle latency, and hold o_rsp_valid/rdata/err stable until it is consumed.
REQ-018 SHALL return o_rsp_err=1 with no state change when addr[1:0]!=0 or addr>0x10.
REQ-019 SHALL sample read data at the acceptance edge, reflecting register values before that edge's updates.
REQ-020 SHALL advance an internal prescale counter 0..PRESCALE-1 every cycle, and increment mtime by 1 when the counter wraps; with PRESCALE=1, mtime increments every cycle.
REQ-021 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0 with no other effect.
REQ-022 SHALL give priority to a write of an mtime half over the increment in the same cycle: the written half takes the written value, and the other half keeps its old value with no carry applied.
REQ-023 SHALL NOT reset the prescale counter on a write to mtime.
REQ-024 SHALL register o_mtip each cycle as (mtime >= mtimecmp), an unsigned 64-bit compare of the current register values, so o_mtip lags by 1 cycle.
REQ-025 SHALL clear o_mtip only by mtimecmp > mtime, with no sticky state.
REQ-026 SHALL drive o_msip directly from the msip register bit.

Reset
REQ-027 SHALL, while i_rst_n=0, asynchronously force: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, prescale counter=0, o_mtip=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
REQ-028 SHALL drive o_req_ready=1 during and after reset.
REQ-029 SHALL discard any pending response when reset asserts mid-transaction.
REQ-030 SHALL release reset with no spurious response and with o_mtip low.

Structure
REQ-031 SHALL place the offset constants (MTIMER_OFF_MTIME_LO … MTIMER_OFF_MSIP) and the 5-bit address typedef in cotm32_priv_pkg.
REQ-032 SHALL take MXLEN from cotm32_pkg.
REQ-033 SHALL use one sub-module, tick_gen (prescale counter emitting a 1-cycle o_tick pulse), parameterised by PRESCALE.

Verification
REQ-034 SHALL cover, PRESCALE=1: after reset, read 0x00 at cycle 10 -> rdata equals the mtime value at acceptance, with rsp_valid 1 cycle later.
REQ-035 SHALL cover: write 0x00=0xFFFF_FFFE, 0x04=0, then read 0x04 three cycles later -> 0x0000_0001, showing the carry across halves.
REQ-036 SHALL cover: write mtimecmp=0x0000_0000_0000_0040 while mtime<0x40 -> o_mtip rises exactly 1 cycle after mtime reaches 0x40; then write 0x0C=0xFFFF_FFFF -> o_mtip falls the following cycle.
REQ-037 SHALL cover: read 0x02 and read 0x14 -> o_rsp_err=1 and rdata=0; a write to 0x13 leaves all registers unchanged.
REQ-038 SHALL cover: hold i_rsp_ready=0 for 5 cycles -> o_req_ready=0 and the response stays stable; raise i_rsp_ready with a back-to-back request -> one response per cycle.
REQ-039 SHALL cover, PRESCALE=4: mtime increments once every 4 cycles; assert i_rst_n=0 mid-response -> o_rsp_valid=0 immediately, and mtime=0 with o_mtip=0 after release.

Source files
------------

// File: rtl/cotm32_pkg.sv
// Purpose: core-wide constants shared across the cotm32 slice.
// Latency: none (constants only).
// Backpressure: not applicable.
package cotm32_pkg;

    // Native register/bus width of the hart.
    localparam int MXLEN = 32;

endpackage

// File: rtl/cotm32_priv_pkg.sv
// Purpose: privileged-architecture register-map definitions (machine timer block).
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package cotm32_priv_pkg;

    // Byte offset into the machine-timer register window.
    typedef logic [4:0] mtimer_addr_t;

    localparam mtimer_addr_t MTIMER_OFF_MTIME_LO    = 5'h00;
    localparam mtimer_addr_t MTIMER_OFF_MTIME_HI    = 5'h04;
    localparam mtimer_addr_t MTIMER_OFF_MTIMECMP_LO = 5'h08;
    localparam mtimer_addr_t MTIMER_OFF_MTIMECMP_HI = 5'h0C;
    localparam mtimer_addr_t MTIMER_OFF_MSIP        = 5'h10;

    // Misaligned or past the last register: the access is rejected.
    function automatic logic mtimer_addr_illegal(input mtimer_addr_t addr);
        return (addr[1:0] != 2'b00) || (addr > MTIMER_OFF_MSIP);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Purpose: prescale counter 0..PRESCALE-1, o_tick high for the cycle in which it wraps.
// Latency: o_tick is combinational from the counter register.
// Backpressure: none; free-running.
// Ports: i_clk, i_rst_n (async active-low), o_tick (1-cycle pulse; constant high when PRESCALE=1).
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        o_tick = (cnt_q == CNT_LAST);
        cnt_d  = o_tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Purpose: machine timer (mtime/mtimecmp/msip) behind a valid/ready request-response port.
// Latency: response registered 1 cycle after acceptance; o_mtip lags the compare by 1 cycle.
// Backpressure: single response slot; o_req_ready = !o_rsp_valid || i_rsp_ready.
// Ports: i_clk, i_rst_n; request i_req_valid/o_req_ready/i_req_we/i_req_addr/i_req_wdata;
//        response o_rsp_valid/i_rsp_ready/o_rsp_rdata/o_rsp_err; interrupts o_mtip, o_msip.
module mtimer
    import cotm32_pkg::*;
    import cotm32_priv_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [4:0]       i_req_addr,
    input  logic [MXLEN-1:0] i_req_wdata,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [MXLEN-1:0] o_rsp_rdata,
    output logic             o_rsp_err,
    output logic             o_mtip,
    output logic             o_msip
);

    logic tick;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    logic [63:0]      mtime_q,     mtime_d;
    logic [63:0]      mtimecmp_q,  mtimecmp_d;
    logic             msip_q,      msip_d;
    logic             mtip_q,      mtip_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [MXLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q,   rsp_err_d;

    logic             req_fire;
    logic             req_err;
    logic             wr_en;
    logic [MXLEN-1:0] rd_data;

    assign o_req_ready = !rsp_valid_q || i_rsp_ready;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mtip      = mtip_q;
    assign o_msip      = msip_q;

    always_comb begin
        req_fire = i_req_valid && o_req_ready;
        req_err  = mtimer_addr_illegal(i_req_addr);
        wr_en    = req_fire && i_req_we && !req_err;

        // Read mux sees the pre-edge register values.
        rd_data = '0;
        case (i_req_addr)
            MTIMER_OFF_MTIME_LO:    rd_data = mtime_q[31:0];
            MTIMER_OFF_MTIME_HI:    rd_data = mtime_q[63:32];
            MTIMER_OFF_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
            MTIMER_OFF_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
            MTIMER_OFF_MSIP:        rd_data = {{(MXLEN-1){1'b0}}, msip_q};
            default:                rd_data = '0;
        endcase

        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        // A write to either mtime half wins over the tick: the written half
        // takes the bus value, the other half is held and no carry crosses.
        if (wr_en) begin
            case (i_req_addr)
                MTIMER_OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], i_req_wdata};
                MTIMER_OFF_MTIME_HI:    mtime_d = {i_req_wdata, mtime_q[31:0]};
                MTIMER_OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = i_req_wdata;
                MTIMER_OFF_MTIMECMP_HI: mtimecmp_d[63:32] = i_req_wdata;
                MTIMER_OFF_MSIP:        msip_d = i_req_wdata[0];
                default: ;
            endcase
        end

        mtip_d = (mtime_q >= mtimecmp_q);

        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_rdata_d = (i_req_we || req_err) ? '0 : rd_data;
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            mtip_q      <= mtip_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Purpose: directed self-checking bench for mtimer (PRESCALE=1 and PRESCALE=4 instances).
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: exercised by holding i_rsp_ready low on the PRESCALE=1 instance.
module tb_mtimer;

    logic        clk;
    int          n_checks = 0;
    int          n_errors = 0;

    // PRESCALE=1 instance
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err, mtip, msip;
    logic [31:0] rsp_rdata;
    int          edges;

    // PRESCALE=4 instance
    logic        rst_n_4 = 1'b0;
    logic        req_valid_4 = 1'b0, req_we_4 = 1'b0, rsp_ready_4 = 1'b1;
    logic [4:0]  req_addr_4 = 5'd0;
    logic [31:0] req_wdata_4 = 32'd0;
    logic        req_ready_4, rsp_valid_4, rsp_err_4, mtip_4, msip_4;
    logic [31:0] rsp_rdata_4;
    int          edges4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mtimer #(.PRESCALE(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_mtip(mtip), .o_msip(msip)
    );

    mtimer #(.PRESCALE(4)) u_dut_4 (
        .i_clk(clk), .i_rst_n(rst_n_4),
        .i_req_valid(req_valid_4), .o_req_ready(req_ready_4), .i_req_we(req_we_4),
        .i_req_addr(req_addr_4), .i_req_wdata(req_wdata_4),
        .o_rsp_valid(rsp_valid_4), .i_rsp_ready(rsp_ready_4), .o_rsp_rdata(rsp_rdata_4),
        .o_rsp_err(rsp_err_4), .o_mtip(mtip_4), .o_msip(msip_4)
    );

    // Rising edges since reset release; with no mtime writes, mtime after
    // edge k is k (PRESCALE=1) or k/4 (PRESCALE=4).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(posedge clk or negedge rst_n_4) begin
        if (!rst_n_4) edges4 <= 0;
        else          edges4 <= edges4 + 1;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    // Single transaction, called on a falling edge with the slot free.
    // Returns the response as seen one cycle after acceptance, and the
    // edge count at the drive point (= pre-acceptance mtime for PRESCALE=1).
    task automatic do_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output logic vld,
                          output int e);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
        e = edges;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rd = rsp_rdata; err = rsp_err; vld = rsp_valid;
    endtask

    task automatic do_req4(input logic [4:0] addr, output logic [31:0] rd, output logic vld);
        req_valid_4 = 1'b1; req_we_4 = 1'b0; req_addr_4 = addr; rsp_ready_4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_4 = 1'b0;
        rd = rsp_rdata_4; vld = rsp_valid_4;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n_4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (mtip !== 1'b0) begin n_errors++; $display("FAIL reset_mtip: got %b want 0", mtip); end
        n_checks++; if (msip !== 1'b0) begin n_errors++; $display("FAIL reset_msip: got %b want 0", msip); end
        rst_n = 1'b1; rst_n_4 = 1'b1;
    endtask

    // Read of mtime_lo accepted on the 10th edge after release.
    task automatic test_read_latency();
        logic [31:0] rd; logic err, vld; int e;
        while (edges < 9) @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL no_spurious_rsp: got %b want 0", rsp_valid); end
        do_req(1'b0, 5'h00, 32'd0, rd, err, vld, e);
        n_checks++; if (vld !== 1'b1) begin n_errors++; $display("FAIL read10_valid: got %b want 1", vld); end
        n_checks++; if (rd !== 32'd9) begin n_errors++; $display("FAIL read10_rdata: got %h want %h", rd, 32'd9); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL read10_err: got %b want 0", err); end
    endtask

    task automatic test_reset_values();
        logic [31:0] rd; logic err, vld; int e;
        do_req(1'b0, 5'h08, 32'd0, rd, err, vld, e);
        n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cmp_lo_reset: got %h want ffffffff", rd); end
        do_req(1'b0, 5'h0C, 32'd0, rd, err, vld, e);
        n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cmp_hi_reset: got %h want ffffffff", rd); end
        do_req(1'b0, 5'h10, 32'd0, rd, err, vld, e);
        n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL msip_reset: got %h want 0", rd); end
    endtask

    task automatic test_carry();
        logic [31:0] rd; logic err, vld; int e;
        do_req(1'b1, 5'h00, 32'hFFFF_FFFE, rd, err, vld, e);
        n_checks++; if (rd !== 32'd0 || err !== 1'b0) begin n_errors++; $display("FAIL write_rsp: got rdata %h err %b want 0/0", rd, err); end
        do_req(1'b1, 5'h04, 32'd0, rd, err, vld, e);
        @(negedge clk);
        @(negedge clk);
        do_req(1'b0, 5'h04, 32'd0, rd, err, vld, e);
        n_checks++; if (rd !== 32'h0000_0001) begin n_errors++; $display("FAIL carry_hi: got %h want 00000001", rd); end
    endtask

    task automatic test_mtip();
        logic [31:0] rd; logic err, vld; int e;
        apply_reset();
        do_req(1'b1, 5'h0C, 32'd0, rd, err, vld, e);
        do_req(1'b1, 5'h08, 32'h40, rd, err, vld, e);
        n_checks++; if (mtip !== 1'b0) begin n_errors++; $display("FAIL mtip_early: got %b want 0", mtip); end
        while (edges < 64) @(negedge clk);
        n_checks++; if (mtip !== 1'b0) begin n_errors++; $display("FAIL mtip_at_reach: got %b want 0", mtip); end
        @(negedge clk);
        n_checks++; if (mtip !== 1'b1) begin n_errors++; $display("FAIL mtip_rise: got %b want 1", mtip); end
        do_req(1'b1, 5'h0C, 32'hFFFF_FFFF, rd, err, vld, e);
        n_checks++; if (mtip !== 1'b1) begin n_errors++; $display("FAIL mtip_hold: got %b want 1", mtip); end
        @(negedge clk);
        n_checks++; if (mtip !== 1'b0) begin n_errors++; $display("FAIL mtip_fall: got %b want 0", mtip); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic err, vld; int e;
        do_req(1'b1, 5'h10, 32'hFFFF_FFFF, rd, err, vld, e);
        n_checks++; if (msip !== 1'b1) begin n_errors++; $display("FAIL msip_set: got %b want 1", msip); end
        do_req(1'b0, 5'h10, 32'd0, rd, err, vld, e);
        n_checks++; if (rd !== 32'd1) begin n_errors++; $display("FAIL msip_read: got %h want 00000001", rd); end
        do_req(1'b0, 5'h02, 32'd0, rd, err, vld, e);
        n_checks++; if (err !== 1'b1 || rd !== 32'd0) begin n_errors++; $display("FAIL rd_misaligned: got err %b rdata %h want 1/0", err, rd); end
        do_req(1'b0, 5'h14, 32'd0, rd, err, vld, e);
        n_checks++; if (err !== 1'b1 || rd !== 32'd0) begin n_errors++; $display("FAIL rd_range: got err %b rdata %h want 1/0", err, rd); end
        do_req(1'b1, 5'h13, 32'd0, rd, err, vld, e);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL wr13_err: got %b want 1", err); end
        n_checks++; if (msip !== 1'b1) begin n_errors++; $display("FAIL wr13_msip: got %b want 1", msip); end
        do_req(1'b1, 5'h01, 32'hDEAD_0000, rd, err, vld, e);
        do_req(1'b0, 5'h00, 32'd0, rd, err, vld, e);
        n_checks++; if (rd !== 32'(e)) begin n_errors++; $display("FAIL wr01_mtime: got %h want %h", rd, 32'(e)); end
        do_req(1'b0, 5'h08, 32'd0, rd, err, vld, e);
        n_checks++; if (rd !== 32'h40) begin n_errors++; $display("FAIL wr13_cmp_lo: got %h want 00000040", rd); end
    endtask

    task automatic test_back_to_back();
        int e0;
        apply_reset();
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h00;
        e0 = edges;
        @(posedge clk);
        @(negedge clk);
        req_addr = 5'h08;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'(e0))
                begin n_errors++; $display("FAIL hold_%0d: got rdy %b vld %b rdata %h want 0/1/%h", i, req_ready, rsp_valid, rsp_rdata, 32'(e0)); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_FFFF)
            begin n_errors++; $display("FAIL b2b_1: got vld %b rdata %h want 1/ffffffff", rsp_valid, rsp_rdata); end
        req_addr = 5'h10;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
            begin n_errors++; $display("FAIL b2b_2: got vld %b rdata %h err %b want 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_prescale4();
        int          tgt [5] = '{3, 4, 7, 8, 12};
        logic [31:0] exp [5] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3};
        logic [31:0] rd; logic vld;
        rst_n_4 = 1'b0;
        @(negedge clk);
        rst_n_4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            while (edges4 < tgt[i]) @(negedge clk);
            do_req4(5'h00, rd, vld);
            n_checks++; if (rd !== exp[i]) begin n_errors++; $display("FAIL ps4_read_%0d: got %h want %h", i, rd, exp[i]); end
        end
        // Leave a response pending, then reset in the middle of it.
        rsp_ready_4 = 1'b0; req_valid_4 = 1'b1; req_addr_4 = 5'h08;
        @(posedge clk);
        @(negedge clk);
        req_valid_4 = 1'b0;
        n_checks++; if (rsp_valid_4 !== 1'b1) begin n_errors++; $display("FAIL ps4_pending: got %b want 1", rsp_valid_4); end
        #2 rst_n_4 = 1'b0;
        #1;
        n_checks++; if (rsp_valid_4 !== 1'b0 || rsp_rdata_4 !== 32'd0 || req_ready_4 !== 1'b1)
            begin n_errors++; $display("FAIL ps4_async_rst: got vld %b rdata %h rdy %b want 0/0/1", rsp_valid_4, rsp_rdata_4, req_ready_4); end
        @(negedge clk);
        rst_n_4 = 1'b1;
        do_req4(5'h00, rd, vld);
        n_checks++; if (rd !== 32'd0 || vld !== 1'b1) begin n_errors++; $display("FAIL ps4_post_rst_mtime: got %h vld %b want 0/1", rd, vld); end
        n_checks++; if (mtip_4 !== 1'b0) begin n_errors++; $display("FAIL ps4_post_rst_mtip: got %b want 0", mtip_4); end
        @(negedge clk);
        n_checks++; if (rsp_valid_4 !== 1'b0) begin n_errors++; $display("FAIL ps4_no_spurious: got %b want 0", rsp_valid_4); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_reset_values();
        test_carry();
        test_mtip();
        test_illegal();
        test_back_to_back();
        test_prescale4();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
